// File: rtl/interleaver_commutator_ctrl.sv
// interleaver_commutator_ctrl: commutator/scheduler for a fifo_shift_ram convolutional interleaver
// Steps the branch, strobes the RAM levels, merges bypass and RAM data, tracks sync and priming.
module interleaver_commutator_ctrl #(
  parameter int NBR        = 12,
  parameter int M          = 17,
  parameter int FRAME_LEN  = 204,
  parameter bit SYNC_ALIGN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  input  logic           in_sync,
  output logic [NBR-2:0] ram_push,
  output logic [3:0]     ram_sel,
  output logic           ram_re,
  output logic [7:0]     ram_din,
  input  logic [7:0]     ram_dout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic           out_sync,
  output logic           primed,
  output logic           sync_err
);
  typedef enum logic {ALIGN, RUN} state_t;
  localparam logic [11:0] PSAT = 12'(NBR * (NBR - 1) * M);
  state_t state, state_nxt;
  logic [3:0] branch, branch_nxt, eb;
  logic [7:0] byte_cnt, cnt_nxt, ecnt, byp_reg;
  logic [11:0] prime_cnt;
  logic acc, proc, mis, realign, src_ram;
  // Unsynced bytes in ALIGN are swallowed even under output backpressure.
  always_comb begin
    in_ready = (state == ALIGN && !in_sync) || !out_valid || out_ready;
    acc = in_valid && in_ready;
    proc = acc && (state == RUN || in_sync);
    mis = acc && state == RUN && in_sync && byte_cnt != 8'd0;
    realign = state == ALIGN || (SYNC_ALIGN && mis);
    eb = realign ? 4'd0 : branch;
    ecnt = realign ? 8'd0 : byte_cnt;
    branch_nxt = proc ? (eb == 4'(NBR - 1) ? 4'd0 : eb + 4'd1) : branch;
    cnt_nxt = proc ? (ecnt == 8'(FRAME_LEN - 1) ? 8'd0 : ecnt + 8'd1) : byte_cnt;
    state_nxt = proc ? RUN : state;
    ram_re = proc && eb != 4'd0;
    ram_sel = ram_re ? eb - 4'd1 : 4'd0;
    ram_push = ram_re ? {{(NBR - 2){1'b0}}, 1'b1} << ram_sel : '0;
    ram_din = in_data;
    out_data = src_ram ? ram_dout : byp_reg;
    primed = prime_cnt == PSAT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ALIGN;
      branch <= 4'd0;
      byte_cnt <= 8'd0;
      prime_cnt <= 12'd0;
      out_valid <= 1'b0;
      out_sync <= 1'b0;
      sync_err <= 1'b0;
      byp_reg <= 8'd0;
      src_ram <= 1'b0;
    end else begin
      state <= state_nxt;
      branch <= branch_nxt;
      byte_cnt <= cnt_nxt;
      sync_err <= mis;
      if (proc && prime_cnt != PSAT) prime_cnt <= prime_cnt + 12'd1;
      if (proc) begin
        out_valid <= 1'b1;
        out_sync <= in_sync;
        src_ram <= eb != 4'd0;
        if (eb == 4'd0) byp_reg <= in_data;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_interleaver_commutator_ctrl.sv
// tb_interleaver_commutator_ctrl: directed bench with a behavioural fifo_shift_ram stand-in
module tb_interleaver_commutator_ctrl;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sync = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'd0, ram_dout, ram_din, out_data, ram_din0, out_data0;
  logic in_ready, ram_re, out_valid, out_sync, primed, sync_err;
  logic in_ready0, ram_re0, out_valid0, out_sync0, primed0, sync_err0;
  logic [10:0] ram_push, ram_push0;
  logic [3:0] ram_sel, ram_sel0;
  logic [7:0] mem [1:11][0:186];
  int ptr [1:11];
  logic [7:0] hist [0:2299];
  int lv;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign lv = int'(ram_sel) + 1;
  interleaver_commutator_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sync(in_sync), .ram_push(ram_push), .ram_sel(ram_sel), .ram_re(ram_re), .ram_din(ram_din),
    .ram_dout(ram_dout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sync(out_sync), .primed(primed), .sync_err(sync_err)
  );
  interleaver_commutator_ctrl #(.SYNC_ALIGN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_sync(in_sync), .ram_push(ram_push0), .ram_sel(ram_sel0), .ram_re(ram_re0), .ram_din(ram_din0),
    .ram_dout(ram_dout), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_sync(out_sync0), .primed(primed0), .sync_err(sync_err0)
  );
  // Level i behaves as an i*17-deep FIFO: each push returns the byte pushed i*17 pushes earlier.
  always @(posedge clk) begin
    if (reset) begin
      for (int l = 1; l <= 11; l++) begin
        ptr[l] <= 0;
        for (int j = 0; j < 187; j++) mem[l][j] <= 8'd0;
      end
      ram_dout <= 8'd0;
    end else if (ram_re) begin
      ram_dout <= mem[lv][ptr[lv]];
      mem[lv][ptr[lv]] <= ram_din;
      ptr[lv] <= (ptr[lv] == lv * 17 - 1) ? 0 : ptr[lv] + 1;
    end
  end
  task automatic do_reset;
    reset = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_sync, primed, sync_err, ram_re, in_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags got %b want 000001", {out_valid, out_sync, primed, sync_err, ram_re, in_ready});
    end
    checks++;
    if (ram_push !== 11'd0) begin errors++; $display("FAIL reset_push got %h want 000", ram_push); end
    @(posedge clk); #1;
  endtask
  task automatic test_basic;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      int b = k % 12;
      logic [10:0] ep = (b == 0) ? 11'd0 : 11'd1 << (b - 1);
      logic [3:0] es = (b == 0) ? 4'd0 : 4'(b - 1);
      in_valid = 1'b1; in_data = 8'(k); in_sync = (k == 0);
      @(negedge clk);
      checks++;
      if ({ram_re, ram_sel, ram_push} !== {b != 0, es, ep}) begin
        errors++;
        $display("FAIL basic_strobe k=%0d got re=%b sel=%0d push=%h want re=%b sel=%0d push=%h", k, ram_re, ram_sel, ram_push, b != 0, es, ep);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_sync} !== {1'b1, k == 0}) begin
        errors++; $display("FAIL basic_valid k=%0d got %b want %b", k, {out_valid, out_sync}, {1'b1, k == 0});
      end
      if (b == 0) begin
        checks++;
        if (out_data !== 8'(k)) begin errors++; $display("FAIL basic_bypass k=%0d got %h want %h", k, out_data, 8'(k)); end
      end
    end
    in_valid = 1'b0; in_sync = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask
  task automatic test_align;
    do_reset();
    in_valid = 1'b1; in_sync = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_data = 8'(k);
      @(negedge clk);
      checks++;
      if ({in_ready, ram_re, ram_push} !== {2'b10, 11'd0}) begin
        errors++; $display("FAIL align_drop k=%0d got rdy=%b re=%b push=%h want 1 0 000", k, in_ready, ram_re, ram_push);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL align_out k=%0d got %b want 0", k, out_valid); end
    end
    in_data = 8'h5A; in_sync = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, ram_push} !== {1'b1, 11'd0}) begin errors++; $display("FAIL align_sync_push got %b want 1_000", {in_ready, ram_push}); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_sync, out_data} !== {2'b11, 8'h5A}) begin
      errors++; $display("FAIL align_sync_out got %b %b %h want 1 1 5a", out_valid, out_sync, out_data);
    end
    in_data = 8'h11; in_sync = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_push !== 11'h001) begin errors++; $display("FAIL align_next_push got %h want 001", ram_push); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_prime;
    do_reset();
    for (int k = 0; k < 2300; k++) begin
      int b = k % 12;
      in_valid = 1'b1; in_data = 8'(k); in_sync = (k == 0 || k == 204); hist[k] = 8'(k);
      @(posedge clk); #1;
      checks++;
      if ({primed, sync_err} !== {k >= 2243, 1'b0}) begin
        errors++; $display("FAIL prime_flags k=%0d got %b want %b", k, {primed, sync_err}, {k >= 2243, 1'b0});
      end
      if (k >= b * 204) begin
        checks++;
        if (out_data !== hist[k - b * 204]) begin
          errors++; $display("FAIL prime_delay k=%0d b=%0d got %h want %h", k, b, out_data, hist[k - b * 204]);
        end
      end
    end
    in_sync = 1'b0;
  endtask
  task automatic test_midreset;
    for (int k = 2300; k < 2310; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      @(posedge clk); #1;
    end
    checks++;
    if (primed !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b want 1", primed); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({out_valid, primed, sync_err, out_sync} !== 4'b0000) begin
      errors++; $display("FAIL midreset_flags got %b want 0000", {out_valid, primed, sync_err, out_sync});
    end
    for (int k = 0; k < 5; k++) begin
      in_data = 8'(k + 40);
      @(negedge clk);
      checks++;
      if ({in_ready, ram_push} !== {1'b1, 11'd0}) begin errors++; $display("FAIL midreset_drop k=%0d got %b want 1_000", k, {in_ready, ram_push}); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out k=%0d got %b want 0", k, out_valid); end
    end
    in_data = 8'h33; in_sync = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_push !== 11'd0) begin errors++; $display("FAIL midreset_sync_push got %h want 000", ram_push); end
    @(posedge clk); #1;
    in_data = 8'h34; in_sync = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_push !== 11'h001) begin errors++; $display("FAIL midreset_next_push got %h want 001", ram_push); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_stall;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1; in_sync = (k == 0); in_data = (k == 12) ? 8'hAB : 8'(k);
      @(posedge clk); #1;
    end
    out_ready = 1'b0; in_data = 8'hCD; in_sync = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, ram_re, ram_push} !== 13'd0) begin
        errors++; $display("FAIL stall_block c=%0d got rdy=%b re=%b push=%h want 0 0 000", c, in_ready, ram_re, ram_push);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_sync, out_data} !== {2'b10, 8'hAB}) begin
        errors++; $display("FAIL stall_hold c=%0d got %b %b %h want 1 0 ab", c, out_valid, out_sync, out_data);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, ram_sel, ram_push} !== {1'b1, 4'd0, 11'h001}) begin
      errors++; $display("FAIL stall_resume got rdy=%b sel=%0d push=%h want 1 0 001", in_ready, ram_sel, ram_push);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_sync} !== 2'b10) begin errors++; $display("FAIL stall_resume_out got %b want 10", {out_valid, out_sync}); end
    in_data = 8'hEF;
    @(negedge clk);
    checks++;
    if (ram_push !== 11'h002) begin errors++; $display("FAIL stall_next_push got %h want 002", ram_push); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_sync_err;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1; in_sync = (k == 0); in_data = 8'(k);
      @(posedge clk); #1;
    end
    in_data = 8'h77; in_sync = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_push, ram_push0} !== {11'd0, 11'h008}) begin
      errors++; $display("FAIL syncerr_push got align=%h noalign=%h want 000 008", ram_push, ram_push0);
    end
    @(posedge clk); #1;
    checks++;
    if ({sync_err, sync_err0, out_data} !== {2'b11, 8'h77}) begin
      errors++; $display("FAIL syncerr_pulse got %b %b %h want 1 1 77", sync_err, sync_err0, out_data);
    end
    in_data = 8'h78; in_sync = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_push, ram_push0} !== {11'h001, 11'h010}) begin
      errors++; $display("FAIL syncerr_next_push got align=%h noalign=%h want 001 010", ram_push, ram_push0);
    end
    @(posedge clk); #1;
    checks++;
    if ({sync_err, sync_err0} !== 2'b00) begin errors++; $display("FAIL syncerr_clear got %b want 00", {sync_err, sync_err0}); end
    in_valid = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_align();
    test_stall();
    test_sync_err();
    test_prime();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
